simpleadder_host: RTL
=====================

# simpleadder_host

Transaction-level host for the serial adder (`simpleadder`). It accepts a parallel operand pair on a valid/ready request port and serializes both operands MSB-first onto the adder's `en_i`/`ina`/`inb` inputs. It then waits for the adder's `en_o` strobe, deserializes the WIDTH+1-bit sum from `out`, and returns it on a single-cycle response port. The block sits between testbench/CPU-side logic and the adder, owning both ends of the adder's serial protocol.

## Interface
- WIDTH, 2, operand width in bits; the sum is WIDTH+1 bits.
- TIMEOUT, 8, maximum cycles spent in WAIT before abort (used only with the watchdog compiled in).

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the transfer is `req_valid && req_ready` at a rising edge.
- req_a  in  WIDTH  operand A, captured on transfer.
- req_b  in  WIDTH  operand B, captured on transfer.
- tx_en  out  1  to adder `en_i`; one-cycle start strobe.
- tx_a  out  1  to adder `ina`; serial operand A.
- tx_b  out  1  to adder `inb`; serial operand B.
- rx_en  in  1  from adder `en_o`; marks the sum MSB.
- rx_bit  in  1  from adder `out`; serial sum.
- rsp_valid  out  1  one-cycle pulse; the sum is valid.
- rsp_sum  out  WIDTH+1  assembled sum; holds until the next response.
- rsp_err  out  1  qualified by rsp_valid; timeout abort.

## Operation
- States: IDLE, SEND, WAIT, RECV, DONE. All outputs are registered.
- IDLE: req_ready=1. On transfer, latch A and B into shift registers, clear the bit counter, and go to SEND.
- SEND (WIDTH cycles): drive A[MSB-k] and B[MSB-k] in cycle k. tx_en=1 only in cycle 0. After the last bit, go to WAIT.
- WAIT: tx_a=tx_b=0. When rx_en=1 is sampled, shift rx_bit in as the sum MSB and go to RECV.
- RECV (WIDTH cycles): shift rx_bit in each edge, MSB-first; rx_en is ignored. After the WIDTH-th bit, go to DONE.
- DONE (1 cycle): rsp_valid=1, rsp_sum=assembled value, req_ready=0. Then go to IDLE.
- rx_en/rx_bit are ignored in IDLE, SEND, RECV and DONE.
- req_valid outside IDLE is not accepted; the requester holds it.
- Reset values: req_ready=0 during reset (1 once in IDLE after release); tx_en=tx_a=tx_b=0; rsp_valid=0; rsp_sum=0; rsp_err=0; state=IDLE.
- Reset mid-transaction aborts immediately with no response. The adder has no reset, so the system reset sequence must hold rst_n low at least 2*WIDTH+3 cycles so the adder drains.

## Timing
- Transfer at edge T0. tx_en/MSB are visible after T0, and the adder samples them at T1. Operand bit k is sampled at T1+k.
- With `simpleadder`, WIDTH=2:
  - rx_en=1 is sampled at T4.
  - Sum bits are sampled at T4, T5 and T6.
  - rsp_valid is high in the cycle after T6.
  - The next transfer is possible at T8.
- Throughput: one transaction per 2*WIDTH+4 cycles against `simpleadder`.
- tx_en is never high for more than one consecutive cycle. A new tx_en is never issued before the previous response is delivered.

## Configuration
- `SIMPLEADDER_HOST_TIMEOUT_EN` defined:
  - WAIT counts cycles.
  - If TIMEOUT cycles elapse without rx_en, go to DONE with rsp_err=1 and rsp_sum=0.
  - rx_en on the same edge the count expires wins: the block proceeds normally.
- Undefined:
  - WAIT waits indefinitely.
  - rsp_err is tied 0.
  - The TIMEOUT parameter is unused.

## Test plan
- A=3, B=3 against `simpleadder`:
  - Pin sequence: tx_a/tx_b = 1,1 with tx_en high on the first bit.
  - Response: rsp_valid one cycle after T6 with rsp_sum=3'b110 and rsp_err=0.
- Exhaustive sweep, all 16 (A,B) pairs, back-to-back with req_valid held high:
  - rsp_sum=A+B for each pair.
  - Transfers spaced exactly 8 cycles apart.
  - tx_en never high on two consecutive cycles.
- Busy hold-off: req_valid high from T1 to T6 with new operands 2,1:
  - No transfer until IDLE.
  - Second response is 3'b011.
- Stray rx_en: rx_en pulsed during SEND and RECV using a stub peer:
  - Ignored in both states.
  - Stub returning 1,0,1 after a real rx_en yields rsp_sum=3'b101.
- Timeout, with `SIMPLEADDER_HOST_TIMEOUT_EN` and TIMEOUT=8:
  - Stimulus: stub never asserts rx_en.
  - Response: rsp_valid with rsp_err=1 and rsp_sum=0 exactly 8 cycles after WAIT entry; next request accepted normally.
  - Macro undefined: block stays in WAIT, rsp_valid never asserts.
- Reset mid-SEND: rst_n low between T1 and T2:
  - tx_en, tx_a, tx_b, rsp_valid and req_ready drop to 0 asynchronously.
  - No response issued.
  - After the 7-cycle reset, transaction 1+1 returns 3'b010.

Source files
------------

// File: rtl/simpleadder_host.sv
// simpleadder_host
//
// Transaction-level host for the serial adder (simpleadder). It accepts an
// operand pair on a valid/ready request port and shifts both operands out
// MSB-first on tx_a/tx_b, with a one-cycle tx_en start strobe. It then waits
// for the adder's rx_en strobe and collects the WIDTH+1-bit sum MSB-first
// from rx_bit. The sum is returned on a single-cycle response port.
//
// Optional feature macro: SIMPLEADDER_HOST_TIMEOUT_EN
//   defined   : WAIT is bounded to TIMEOUT cycles. On expiry the block
//               responds with rsp_err=1 and rsp_sum=0.
//   undefined : WAIT waits indefinitely, and rsp_err is tied to 0.
//
// Parameters
//   WIDTH    operand width; the sum is WIDTH+1 bits
//   TIMEOUT  maximum number of cycles spent in WAIT (watchdog build only)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  high in IDLE; a transfer is req_valid && req_ready at an edge
//   req_a/b    operands, captured on transfer
//   tx_en      to adder en_i, one-cycle start strobe
//   tx_a/b     to adder ina/inb, serial operands
//   rx_en      from adder en_o, marks the sum MSB
//   rx_bit     from adder out, serial sum
//   rsp_valid  one-cycle response pulse
//   rsp_sum    assembled sum, held until the next response
//   rsp_err    timeout abort, qualified by rsp_valid
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; req_ready=1
// SEND  | shifting operand bit k out in SEND cycle k; tx_en in cycle 0 only
// WAIT  | serial lines low, waiting for rx_en (bounded by the watchdog)
// RECV  | shifting in the remaining WIDTH sum bits, rx_en ignored
// DONE  | rsp_valid pulse; return to IDLE

module simpleadder_host #(
  parameter int WIDTH   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             tx_en,
  output logic             tx_a,
  output logic             tx_b,
  input  logic             rx_en,
  input  logic             rx_bit,
  output logic             rsp_valid,
  output logic [WIDTH:0]   rsp_sum,
  output logic             rsp_err
);

  // One down-counter serves SEND, RECV and the WAIT watchdog, so it is sized
  // for the larger of the two terminal counts.
  localparam int CNT_MAX = (TIMEOUT > WIDTH) ? TIMEOUT : WIDTH;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_BITS = CW'(WIDTH - 1);
`ifdef SIMPLEADDER_HOST_TIMEOUT_EN
  localparam logic [CW-1:0] CNT_TO = CW'(TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RECV,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_req_ready;
  logic             r_tx_en;
  logic             r_tx_a;
  logic             r_tx_b;
  logic             r_rsp_valid;
  logic [WIDTH:0]   r_rsp_sum;
`ifdef SIMPLEADDER_HOST_TIMEOUT_EN
  logic             r_rsp_err;
`endif

  // r_shift holds the bits collected so far. Appending the current rx_bit
  // gives the value after this edge, which is the full sum on the last edge.
  logic [WIDTH:0] w_shift_nxt;
  assign w_shift_nxt = {r_shift, rx_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_tx_en     <= 1'b0;
      r_tx_a      <= 1'b0;
      r_tx_b      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
`ifdef SIMPLEADDER_HOST_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      r_tx_en     <= 1'b0;
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            // The MSB goes straight onto the pins. The shift registers keep
            // the remaining bits, left-aligned.
            r_tx_en     <= 1'b1;
            r_tx_a      <= req_a[WIDTH-1];
            r_tx_b      <= req_b[WIDTH-1];
            r_a         <= req_a << 1;
            r_b         <= req_b << 1;
            r_cnt       <= CNT_BITS;
            r_req_ready <= 1'b0;
            r_state     <= S_SEND;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_SEND: begin
          if (r_cnt == '0) begin
            r_tx_a  <= 1'b0;
            r_tx_b  <= 1'b0;
`ifdef SIMPLEADDER_HOST_TIMEOUT_EN
            r_cnt   <= CNT_TO;
`endif
            r_state <= S_WAIT;
          end else begin
            r_tx_a <= r_a[WIDTH-1];
            r_tx_b <= r_b[WIDTH-1];
            r_a    <= r_a << 1;
            r_b    <= r_b << 1;
            r_cnt  <= r_cnt - CW'(1);
          end
        end
        S_WAIT: begin
          if (rx_en) begin
            r_shift <= w_shift_nxt[WIDTH-1:0];
            r_cnt   <= CNT_BITS;
            r_state <= S_RECV;
`ifdef SIMPLEADDER_HOST_TIMEOUT_EN
          end else if (r_cnt == '0) begin
            // rx_en is tested first, so a strobe on the expiry edge still wins.
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
`endif
          end
        end
        S_RECV: begin
          r_shift <= w_shift_nxt[WIDTH-1:0];
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_shift_nxt;
`ifdef SIMPLEADDER_HOST_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign tx_en     = r_tx_en;
  assign tx_a      = r_tx_a;
  assign tx_b      = r_tx_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
`ifdef SIMPLEADDER_HOST_TIMEOUT_EN
  assign rsp_err   = r_rsp_err;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
